// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt controller for the board timer/button sources.
//
// Each source is edge-detected into a pending bit. The pending bits are masked
// by an enable register and a priority encoder (index 0 highest) picks the
// source to request. One level interrupt carrying that source's ID is held
// until software acknowledges it or withdraws the request. After that the
// request line is held low for HOLDOFF cycles so the CPU sees a clean gap.
//
// Ports:
//   clk       system clock (clk_100mhz domain)
//   rst       synchronous active-high reset
//   irq_src   source levels, synchronous to clk
//   ic_sel    register window selected by the bus decode
//   ic_we     write strobe, used only when ic_sel=1
//   reg_addr  register index: 0 PENDING(W1C), 1 ENABLE, 2 CLAIM(RO), 3 ACK(WO)
//   wdata     write data
//   rdata     combinational read data
//   int_out   level interrupt request to the CPU
//   int_id    ID of the requested source, valid while int_out=1
module irq_ctrl #(
    parameter int N_SRC   = 4,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             ic_sel,
    input  logic             ic_we,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             int_out,
    output logic [3:0]       int_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(HOLDOFF - 1);

    // Lowest set index wins; scanning downwards lets lower indices overwrite.
    function automatic logic [3:0] prio_enc(input logic [N_SRC-1:0] vec);
        logic [3:0] id;
        id = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            id = vec[i] ? 4'(i) : id;
        end
        return id;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [N_SRC-1:0]   prev_r;
    logic [N_SRC-1:0]   pending_r, pending_nxt_s;
    logic [N_SRC-1:0]   en_r, en_nxt_s;
    logic [3:0]         int_id_r, int_id_nxt_s;
    logic               int_out_r, int_out_nxt_s;
    logic [7:0]         gap_cnt_r, gap_cnt_nxt_s;

    logic [N_SRC-1:0]   edge_s;
    logic [N_SRC-1:0]   req_s;
    logic [N_SRC-1:0]   id_onehot_s;
    logic [N_SRC-1:0]   clr_s;
    logic               wr_s;
    logic               ack_hit_s;
    logic               withdrawn_s;

    assign edge_s  = irq_src & ~prev_r;
    assign req_s   = pending_r & en_r;
    assign int_out = int_out_r;
    assign int_id  = int_id_r;

    // Register-window writes and the pending/enable next values.
    always_comb begin
        wr_s = ic_sel & ic_we;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot_s[i] = (int_id_r == 4'(i));
        end
        // int_id_r is always below N_SRC, so a matching ID is also in range.
        ack_hit_s = (state_r == ST_REQ) && wr_s && (reg_addr == 2'd3)
                    && (wdata[3:0] == int_id_r);
        if (wr_s && (reg_addr == 2'd0)) begin
            clr_s = wdata[N_SRC-1:0];
        end else begin
            clr_s = {N_SRC{1'b0}};
        end
        if (ack_hit_s) begin
            clr_s = clr_s | id_onehot_s;
        end else begin
            clr_s = clr_s;
        end
        if (wr_s && (reg_addr == 2'd1)) begin
            en_nxt_s = wdata[N_SRC-1:0];
        end else begin
            en_nxt_s = en_r;
        end
        // A new edge beats a clear of the same bit in the same cycle.
        pending_nxt_s = (pending_r & ~clr_s) | edge_s;
        // Request for the frozen ID disappears once either its pending or enable bit drops.
        withdrawn_s   = ~|(pending_nxt_s & en_nxt_s & id_onehot_s);
    end

    // Request FSM: next state, latched ID, hold-off counter and int_out.
    always_comb begin
        state_nxt_s   = state_r;
        int_id_nxt_s  = int_id_r;
        gap_cnt_nxt_s = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_nxt_s  = ST_REQ;
                    int_id_nxt_s = prio_enc(req_s);
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_hit_s || withdrawn_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        int_out_nxt_s = (state_nxt_s == ST_REQ);
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            prev_r    <= {N_SRC{1'b1}};
            pending_r <= {N_SRC{1'b0}};
            en_r      <= {N_SRC{1'b0}};
            int_id_r  <= 4'd0;
            int_out_r <= 1'b0;
            gap_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            prev_r    <= irq_src;
            pending_r <= pending_nxt_s;
            en_r      <= en_nxt_s;
            int_id_r  <= int_id_nxt_s;
            int_out_r <= int_out_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
        end
    end

    // Read mux; unused bits read as zero.
    always_comb begin
        rdata = 32'd0;
        case (reg_addr)
            2'd0: rdata[N_SRC-1:0] = pending_r;
            2'd1: rdata[N_SRC-1:0] = en_r;
            2'd2: begin
                rdata[31]  = int_out_r;
                rdata[3:0] = int_id_r;
            end
            2'd3:    rdata = 32'd0;
            default: rdata = 32'd0;
        endcase
    end

endmodule
